// File: rtl/sync_shift_ctrl.sv
// Sequencer for the rfin synchroniser: arms it, waits for lock, then opens
// a programmable sh_en window with lock timeout, abort and done/error status.
module sync_shift_ctrl #(
   parameter int CNT_W      = 8,
   parameter int TO_W       = 16,
   parameter int SETTLE_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic             sync_state,
   input  logic [CNT_W-1:0] shift_len,
   input  logic [TO_W-1:0]  timeout,
   output logic             sh_en,
   output logic             fsm_rst,
   output logic             busy,
   output logic             done,
   output logic             timeout_err,
   output logic [CNT_W-1:0] shift_cnt
);

   localparam int SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [SC_W-1:0] SC_INIT = SC_W'(SETTLE_CYC - 1);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ARM    = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_SETTLE = 3'd3;
   localparam logic [2:0] S_SHIFT  = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;
   localparam logic [2:0] S_ERR    = 3'd6;
   localparam logic [2:0] S_CLEAR  = 3'd7;

   logic [2:0]       state;
   logic [CNT_W-1:0] len_q;
   logic [TO_W-1:0]  to_q;
   logic [TO_W-1:0]  tcnt;
   logic [SC_W-1:0]  scnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         len_q     <= '0;
         to_q      <= '0;
         tcnt      <= '0;
         scnt      <= '0;
         shift_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start && !abort) begin
                  state     <= S_ARM;
                  len_q     <= shift_len;
                  to_q      <= timeout;
                  shift_cnt <= '0;
               end
            end
            S_ARM: begin
               if (abort) state <= S_CLEAR;
               else begin
                  state <= S_WAIT;
                  tcnt  <= to_q;
               end
            end
            S_WAIT: begin
               // Lock takes priority over a timeout expiring on the same edge.
               if (abort) state <= S_CLEAR;
               else if (sync_state) begin
                  state <= S_SETTLE;
                  scnt  <= SC_INIT;
               end else if (to_q != '0) begin
                  if (tcnt == TO_W'(1)) state <= S_ERR;
                  else                  tcnt  <= tcnt - TO_W'(1);
               end
            end
            S_SETTLE: begin
               if (abort) state <= S_CLEAR;
               else if (scnt == '0) state <= (len_q == '0) ? S_DONE : S_SHIFT;
               else scnt <= scnt - SC_W'(1);
            end
            S_SHIFT: begin
               // Count the cycle just issued, even when it is cut short by abort.
               shift_cnt <= shift_cnt + CNT_W'(1);
               if (abort) state <= S_CLEAR;
               else if (shift_cnt == len_q - CNT_W'(1)) state <= S_DONE;
            end
            S_DONE, S_ERR, S_CLEAR: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   assign sh_en       = (state == S_SHIFT);
   assign fsm_rst     = (state == S_ARM) || (state == S_ERR) || (state == S_CLEAR);
   assign busy        = (state != S_IDLE);
   assign done        = (state == S_DONE);
   assign timeout_err = (state == S_ERR);

endmodule

// File: tb/tb_sync_shift_ctrl.sv
// Bench for sync_shift_ctrl: each capture is predicted as a timeline of phases
// derived from start/lock/abort edges, then compared cycle by cycle.
module tb_sync_shift_ctrl;
   localparam int CNT_W = 8;
   localparam int TO_W  = 16;
   localparam int S     = 2;

   logic             clk = 1'b0;
   logic             rst, start, abort, sync_state;
   logic [CNT_W-1:0] shift_len;
   logic [TO_W-1:0]  timeout;
   logic             sh_en, fsm_rst, busy, done, timeout_err;
   logic [CNT_W-1:0] shift_cnt;

   always #5 clk = ~clk;

   sync_shift_ctrl #(.CNT_W(CNT_W), .TO_W(TO_W), .SETTLE_CYC(S)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .sync_state(sync_state),
      .shift_len(shift_len), .timeout(timeout), .sh_en(sh_en), .fsm_rst(fsm_rst),
      .busy(busy), .done(done), .timeout_err(timeout_err), .shift_cnt(shift_cnt)
   );

   typedef enum int {P_IDLE, P_ARM, P_WAIT, P_SETTLE, P_SHIFT, P_DONE, P_ERR, P_CLEAR} ph_t;

   int checks = 0;
   int errors = 0;
   int cur_len, cur_to, cur_m, cur_a;
   int last_cnt = 0;

   // Phase seen j samples after the start edge, ignoring abort. m = edge with lock pulse.
   function automatic ph_t ph_u(int j);
      bit locked;
      if (j < 0)  return P_IDLE;
      if (j == 0) return P_ARM;
      locked = (cur_m >= 2) && (cur_to == 0 || cur_m <= cur_to + 1);
      if (locked) begin
         if (j < cur_m)                return P_WAIT;
         if (j < cur_m + S)            return P_SETTLE;
         if (j < cur_m + S + cur_len)  return P_SHIFT;
         if (j == cur_m + S + cur_len) return P_DONE;
         return P_IDLE;
      end
      if (cur_to == 0)     return P_WAIT;
      if (j <= cur_to)     return P_WAIT;
      if (j == cur_to + 1) return P_ERR;
      return P_IDLE;
   endfunction

   function automatic ph_t ph(int j);
      ph_t pa;
      if (cur_a >= 1 && j >= cur_a) begin
         pa = ph_u(cur_a - 1);
         if (pa inside {P_ARM, P_WAIT, P_SETTLE, P_SHIFT})
            return (j == cur_a) ? P_CLEAR : P_IDLE;
      end
      return ph_u(j);
   endfunction

   // shift_cnt = number of sh_en cycles already issued in this capture.
   function automatic int exp_cnt(int j);
      int n = 0;
      for (int k = 0; k < j; k++) if (ph(k) == P_SHIFT) n++;
      return n;
   endfunction

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input ph_t p, input int cnt);
      chk({tag, ".sh_en"},       32'(sh_en),       32'(p == P_SHIFT));
      chk({tag, ".fsm_rst"},     32'(fsm_rst),     32'(p inside {P_ARM, P_ERR, P_CLEAR}));
      chk({tag, ".busy"},        32'(busy),        32'(p != P_IDLE));
      chk({tag, ".done"},        32'(done),        32'(p == P_DONE));
      chk({tag, ".timeout_err"}, 32'(timeout_err), 32'(p == P_ERR));
      chk({tag, ".shift_cnt"},   32'(shift_cnt),   32'(cnt));
   endtask

   // Called at a negedge with the DUT idle; stop_j cuts the capture short.
   task automatic run(input string tag, input int len, input int to, input int m,
                      input int a, input int stop_j);
      int   last_j;
      ph_t  p;
      cur_len = len; cur_to = to; cur_m = m; cur_a = a;
      last_j = 1;
      while (last_j < 400 && ph(last_j) != P_IDLE) last_j++;
      start = 1'b1; abort = 1'b0; sync_state = 1'b0;
      shift_len = CNT_W'(len); timeout = TO_W'(to);
      for (int j = 0; j <= last_j + 1 && j <= stop_j; j++) begin
         @(negedge clk);
         p = ph(j);
         check_outs($sformatf("%s[%0d]", tag, j), p, exp_cnt(j));
         // Busy-time start and config changes must have no effect.
         start      = (p != P_IDLE) ? 1'($urandom_range(0, 1)) : 1'b0;
         shift_len  = CNT_W'($urandom);
         timeout    = TO_W'($urandom);
         sync_state = (j + 1 == m);
         abort      = (j + 1 == a) ||
                      ((p inside {P_DONE, P_ERR, P_CLEAR}) && $urandom_range(0, 3) == 0);
      end
      start = 1'b0; abort = 1'b0; sync_state = 1'b0;
      last_cnt = exp_cnt(last_j + 1);
   endtask

   initial begin
      int len, to, m, a;
      rst = 1'b1; start = 1'b0; abort = 1'b0; sync_state = 1'b0;
      shift_len = '0; timeout = '0;
      repeat (3) @(negedge clk);
      check_outs("reset", P_IDLE, 0);
      rst = 1'b0;
      @(negedge clk);

      // Reset held three cycles mid-window, then a fresh capture.
      run("pre_rst", 5, 0, 3, 0, 3 + S + 1);
      rst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_outs($sformatf("rst_mid[%0d]", i), P_IDLE, 0);
      end
      rst = 1'b0;
      run("post_rst", 3, 0, 2, 0, 1000);

      run("len5", 5, 0, 4, 0, 1000);
      run("tmo10", 4, 10, 0, 0, 1000);
      run("abort3", 8, 0, 3, 3 + S + 3, 1000);
      run("len0", 0, 0, 5, 0, 1000);
      run("tmo_edge_lock", 2, 6, 7, 0, 1000);
      run("abort_arm", 4, 0, 0, 1, 1000);

      // start and abort together in IDLE: nothing happens.
      start = 1'b1; abort = 1'b1; shift_len = 8'd9;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_outs($sformatf("start_abort[%0d]", i), P_IDLE, last_cnt);
      end

      for (int r = 0; r < 25; r++) begin
         len = $urandom_range(0, 12);
         to  = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 12);
         m   = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(2, 16);
         a   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 30) : 0;
         if (m == 0 && to == 0 && a == 0) a = $urandom_range(1, 20);
         run($sformatf("rnd%0d", r), len, to, m, a, 1000);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
